psum_acc_fifo: RTL and testbench

Multi-channel partial-sum FIFO for the CNN accelerator's output path: buffers NUM_CH signed psum lanes per entry on a single clock.
- On write it optionally adds an incoming psum vector, with per-lane saturation.
- On read it either pops or peeks, so one entry can be reused across passes.
- It replaces the single-lane end-of-array FIFO and adds full/empty/count/error status for the controller.

---
 rtl/psum_fifo_pkg.sv | 35 +++
 rtl/psum_acc_fifo_if.sv | 38 +++
 rtl/psum_sat_add.sv | 34 +++
 rtl/psum_acc_fifo.sv | 136 +++++++++++++
 tb/tb_psum_acc_fifo.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/psum_fifo_pkg.sv
// -----------------------------------------------------------------------------
// psum_fifo_pkg
//   Shared definitions for the partial-sum accumulate FIFO.
//   - PSUM_DW / PSUM_NUM_CH : default lane width and lane count
//   - LANE_MAX / LANE_MIN   : signed clamp limits for a PSUM_DW-bit lane
//   - sat_add()             : signed add with saturation at PSUM_DW bits
//   - lane_unpack()         : extract lane idx from a packed lane vector
// -----------------------------------------------------------------------------
package psum_fifo_pkg;

    localparam int unsigned PSUM_DW     = 16;
    localparam int unsigned PSUM_NUM_CH = 4;

    typedef logic signed [PSUM_DW-1:0] lane_t;

    localparam lane_t LANE_MAX = {1'b0, {(PSUM_DW-1){1'b1}}};
    localparam lane_t LANE_MIN = {1'b1, {(PSUM_DW-1){1'b0}}};

    // The sum is formed one bit wider than a lane; a mismatch between the two
    // top bits means the true result left the representable range.
    function automatic lane_t sat_add(input lane_t a, input lane_t b);
        logic signed [PSUM_DW:0] s;
        s = {a[PSUM_DW-1], a} + {b[PSUM_DW-1], b};
        if (s[PSUM_DW] != s[PSUM_DW-1]) begin
            return s[PSUM_DW] ? LANE_MIN : LANE_MAX;
        end
        return s[PSUM_DW-1:0];
    endfunction

    function automatic lane_t lane_unpack(input logic [PSUM_NUM_CH*PSUM_DW-1:0] vec,
                                          input int unsigned                    idx);
        return vec[idx*PSUM_DW +: PSUM_DW];
    endfunction

endpackage

// File: rtl/psum_acc_fifo_if.sv
// -----------------------------------------------------------------------------
// psum_acc_fifo_if
//   Bus between the array controller (master) and the psum FIFO (slave).
//   Write side : wr_en, acc_en, wr_data, psum_in
//   Read side  : rd_en, rd_keep -> rd_data, rd_valid
//   Status     : full, empty, count, overflow, underflow
// -----------------------------------------------------------------------------
interface psum_acc_fifo_if
    import psum_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PSUM_DW,
    parameter int unsigned NUM_CH     = PSUM_NUM_CH,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                         wr_en;
    logic                         acc_en;
    logic [NUM_CH*DATA_WIDTH-1:0] wr_data;
    logic [NUM_CH*DATA_WIDTH-1:0] psum_in;
    logic                         rd_en;
    logic                         rd_keep;
    logic [NUM_CH*DATA_WIDTH-1:0] rd_data;
    logic                         rd_valid;
    logic                         full;
    logic                         empty;
    logic [ADDR_WIDTH:0]          count;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output wr_en, acc_en, wr_data, psum_in, rd_en, rd_keep,
        input  rd_data, rd_valid, full, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, acc_en, wr_data, psum_in, rd_en, rd_keep,
        output rd_data, rd_valid, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/psum_sat_add.sv
// -----------------------------------------------------------------------------
// psum_sat_add
//   One lane of signed saturating addition: y = clamp(a + b).
//   a, b : DATA_WIDTH-bit signed operands
//   y    : DATA_WIDTH-bit signed result, clamped to [min, max]
// -----------------------------------------------------------------------------
module psum_sat_add
    import psum_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PSUM_DW
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] y
);

    generate
        if (DATA_WIDTH == PSUM_DW) begin : g_pkg
            always_comb y = sat_add(a, b);
        end else begin : g_generic
            // Same clamp as the package function, sized for a non-default lane.
            logic signed [DATA_WIDTH:0] sum;
            always_comb begin
                sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
                y   = sum[DATA_WIDTH-1:0];
                if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
                    y = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                        : {1'b0, {(DATA_WIDTH-1){1'b1}}};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/psum_acc_fifo.sv
// -----------------------------------------------------------------------------
// psum_acc_fifo
//   Multi-lane partial-sum FIFO with optional saturating accumulate on write
//   and pop-or-peek on read.
//   clk1   : clock, rising edge
//   rd_clr : asynchronous active-high reset of pointers, count, read regs, flags
//   flush  : synchronous clear, same effect as rd_clr, wins over wr_en/rd_en
//   bus    : write/read handshake and status (psum_acc_fifo_if.slave)
//   Storage is never cleared; only pointers and count are.
// -----------------------------------------------------------------------------
module psum_acc_fifo
    import psum_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PSUM_DW,
    parameter int unsigned NUM_CH     = PSUM_NUM_CH,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic              clk1,
    input  logic              rd_clr,
    input  logic              flush,
    psum_acc_fifo_if.slave    bus
);

    localparam int unsigned W  = NUM_CH * DATA_WIDTH;
    localparam int unsigned CW = ADDR_WIDTH + 1;

    logic [W-1:0]            mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [CW-1:0]           count_q,     count_d;
    logic [W-1:0]            rd_data_q,   rd_data_d;
    logic                    rd_valid_q,  rd_valid_d;
    logic                    overflow_q,  overflow_d;
    logic                    underflow_q, underflow_d;

    logic                    full;
    logic                    empty;
    logic                    push_acc;
    logic                    rd_acc;
    logic                    pop_acc;
    logic                    mem_we;
    logic [W-1:0]            sum_word;
    logic [W-1:0]            wr_word;

    // Per-lane saturating adders feeding the accumulate path.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        psum_sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_sat (
            .a (bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .b (bus.psum_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .y (sum_word[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        push_acc = bus.wr_en & ~full;
        rd_acc   = bus.rd_en & ~empty;
        pop_acc  = rd_acc & ~bus.rd_keep;
        wr_word  = bus.acc_en ? sum_word : bus.wr_data;
        mem_we   = push_acc & ~flush;
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        rd_data_d   = '0;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (bus.wr_en && full) begin
                overflow_d = 1'b1;
            end
            if (rd_acc) begin
                rd_data_d  = mem[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end
            if (bus.rd_en && empty) begin
                underflow_d = 1'b1;
            end
            count_d = count_q + CW'(push_acc) - CW'(pop_acc);
        end
    end

    always_ff @(posedge clk1 or posedge rd_clr) begin
        if (rd_clr) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk1) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= wr_word;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_psum_acc_fifo.sv
// -----------------------------------------------------------------------------
// tb_psum_acc_fifo
//   Directed bench for psum_acc_fifo (16-bit lanes, 4 lanes, depth 16).
// -----------------------------------------------------------------------------
module tb_psum_acc_fifo;

    logic clk1;
    logic rd_clr;
    logic flush;

    int unsigned checks = 0;
    int unsigned errors = 0;

    psum_acc_fifo_if #(.DATA_WIDTH(16), .NUM_CH(4), .ADDR_WIDTH(4)) bus ();

    psum_acc_fifo #(
        .DATA_WIDTH (16),
        .NUM_CH     (4),
        .DEPTH      (16),
        .ADDR_WIDTH (4)
    ) dut (
        .clk1   (clk1),
        .rd_clr (rd_clr),
        .flush  (flush),
        .bus    (bus)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Lane 0 in the low bits.
    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [63:0] ent(input int v);
        return pk(v, v + 1000, -v, 7 - v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    initial begin
        rd_clr          = 1'b1;
        flush           = 1'b0;
        bus.wr_en       = 1'b0;
        bus.acc_en      = 1'b0;
        bus.wr_data     = '0;
        bus.psum_in     = '0;
        bus.rd_en       = 1'b0;
        bus.rd_keep     = 1'b0;
        repeat (2) @(posedge clk1);
        #1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_data", bus.rd_data, 64'd0);
        chk("rst_flags", {62'd0, bus.overflow, bus.underflow}, 64'd0);
        rd_clr = 1'b0;
        tick();

        // Fill to full.
        for (int k = 0; k < 16; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = pk(k, k + 1, k + 2, k + 3);
            tick();
        end
        bus.wr_en = 1'b0;
        chk("fill_full", 64'(bus.full), 64'd1);
        chk("fill_count", 64'(bus.count), 64'd16);

        // 17th push is dropped.
        bus.wr_en   = 1'b1;
        bus.wr_data = pk(999, 999, 999, 999);
        tick();
        bus.wr_en = 1'b0;
        chk("ovf_count", 64'(bus.count), 64'd16);
        chk("ovf_flag", 64'(bus.overflow), 64'd1);

        // Drain; first pop cycle also pushes, which full rejects.
        for (int k = 0; k < 16; k++) begin
            bus.rd_en   = 1'b1;
            bus.wr_en   = (k == 0);
            bus.wr_data = pk(555, 555, 555, 555);
            tick();
            bus.wr_en = 1'b0;
            chk("drain_data", bus.rd_data, pk(k, k + 1, k + 2, k + 3));
            chk("drain_valid", 64'(bus.rd_valid), 64'd1);
            if (k == 0) chk("full_pushpop_count", 64'(bus.count), 64'd15);
        end
        bus.rd_en = 1'b0;
        tick();
        chk("idle_valid", 64'(bus.rd_valid), 64'd0);
        chk("idle_data", bus.rd_data, 64'd0);
        chk("drain_empty", 64'(bus.empty), 64'd1);

        // Read on empty with a simultaneous push: read rejected, push taken.
        bus.rd_en   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = pk(1, 2, 3, 4);
        tick();
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        chk("unf_valid", 64'(bus.rd_valid), 64'd0);
        chk("unf_data", bus.rd_data, 64'd0);
        chk("unf_flag", 64'(bus.underflow), 64'd1);
        chk("unf_ovf_sticky", 64'(bus.overflow), 64'd1);
        chk("empty_push_count", 64'(bus.count), 64'd1);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_flags", {62'd0, bus.overflow, bus.underflow}, 64'd0);
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_empty", 64'(bus.empty), 64'd1);

        // Saturating accumulate.
        bus.wr_en   = 1'b1;
        bus.acc_en  = 1'b1;
        bus.wr_data = pk(100, -5, 32767, -32768);
        bus.psum_in = pk(23, -7, 1, -1);
        tick();
        bus.wr_data = pk(-32768, 32767, -1, 0);
        bus.psum_in = pk(-1, 1, 1, 0);
        tick();
        bus.wr_en  = 1'b0;
        bus.acc_en = 1'b0;
        bus.rd_en  = 1'b1;
        tick();
        chk("sat_a", bus.rd_data, pk(123, -12, 32767, -32768));
        tick();
        chk("sat_b", bus.rd_data, pk(-32768, 32767, 0, 0));
        bus.rd_en = 1'b0;

        // Peek three times, then pop twice.
        bus.wr_en   = 1'b1;
        bus.wr_data = pk(11, 12, 13, 14);
        tick();
        bus.wr_data = pk(21, 22, 23, 24);
        tick();
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b1;
        bus.rd_keep = 1'b1;
        for (int p = 0; p < 3; p++) begin
            tick();
            chk("peek_data", bus.rd_data, pk(11, 12, 13, 14));
            chk("peek_count", 64'(bus.count), 64'd2);
        end
        bus.rd_keep = 1'b0;
        tick();
        chk("pop_a", bus.rd_data, pk(11, 12, 13, 14));
        tick();
        chk("pop_b", bus.rd_data, pk(21, 22, 23, 24));
        chk("pop_count", 64'(bus.count), 64'd0);
        bus.rd_en = 1'b0;

        // Prefill 8, then 40 cycles of concurrent push+pop across the wrap.
        for (int v = 0; v < 8; v++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = ent(v);
            tick();
        end
        chk("pre_count", 64'(bus.count), 64'd8);
        for (int c = 0; c < 40; c++) begin
            bus.wr_en   = 1'b1;
            bus.rd_en   = 1'b1;
            bus.wr_data = ent(8 + c);
            tick();
            chk("cc_data", bus.rd_data, ent(c));
            chk("cc_count", 64'(bus.count), 64'd8);
        end
        bus.wr_en = 1'b0;

        // Pop down to 5, then async clear while rd_valid is high.
        for (int c = 40; c < 43; c++) begin
            tick();
            chk("pre_clr_data", bus.rd_data, ent(c));
        end
        chk("pre_clr_count", 64'(bus.count), 64'd5);
        rd_clr = 1'b1;
        #2;
        chk("clr_count", 64'(bus.count), 64'd0);
        chk("clr_empty", 64'(bus.empty), 64'd1);
        chk("clr_valid", 64'(bus.rd_valid), 64'd0);
        chk("clr_data", bus.rd_data, 64'd0);
        rd_clr    = 1'b0;
        bus.rd_en = 1'b0;

        bus.wr_en   = 1'b1;
        bus.wr_data = pk(-1, -2, 300, 4000);
        tick();
        bus.wr_en = 1'b0;
        chk("post_push_count", 64'(bus.count), 64'd1);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("post_pop_data", bus.rd_data, pk(-1, -2, 300, 4000));
        chk("post_pop_valid", 64'(bus.rd_valid), 64'd1);
        chk("post_pop_empty", 64'(bus.empty), 64'd1);
        tick();
        chk("post_idle_valid", 64'(bus.rd_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
